// File: rtl/sram_port_arbiter_if.sv
// Requester, SRAM-controller and status signals of the two-port SRAM arbiter.
// slave is the arbiter's view; master is the environment (requesters plus SRAM controller).
interface sram_port_arbiter_if;
    logic        p0_read_en;
    logic        p0_write_en;
    logic [31:0] p0_addr;
    logic [31:0] p0_write_data;
    logic        p0_ready;
    logic [63:0] p0_read_data;

    logic        p1_read_en;
    logic        p1_write_en;
    logic [31:0] p1_addr;
    logic [31:0] p1_write_data;
    logic        p1_ready;
    logic [63:0] p1_read_data;

    logic        SRAM_read_en;
    logic        SRAM_write_en;
    logic [31:0] SRAM_addr;
    logic [31:0] SRAM_write_data;
    logic [63:0] SRAM_read_data;
    logic        SRAM_ready;

    logic [1:0]  grant;
    logic        timeout_err;

    modport slave (
        input  p0_read_en, p0_write_en, p0_addr, p0_write_data,
        output p0_ready, p0_read_data,
        input  p1_read_en, p1_write_en, p1_addr, p1_write_data,
        output p1_ready, p1_read_data,
        output SRAM_read_en, SRAM_write_en, SRAM_addr, SRAM_write_data,
        input  SRAM_read_data, SRAM_ready,
        output grant, timeout_err
    );

    modport master (
        output p0_read_en, p0_write_en, p0_addr, p0_write_data,
        input  p0_ready, p0_read_data,
        output p1_read_en, p1_write_en, p1_addr, p1_write_data,
        input  p1_ready, p1_read_data,
        input  SRAM_read_en, SRAM_write_en, SRAM_addr, SRAM_write_data,
        output SRAM_read_data, SRAM_ready,
        input  grant, timeout_err
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port SRAM arbiter: 1-cycle grant latency, grant held until SRAM_ready or watchdog abort.
// Losing port waits with its request pending; SRAM_ARB_ROUND_ROBIN_EN selects round-robin ties.
module sram_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] LP_WD_LAST = TO_W'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic            w_last_grant_nxt;
    logic [TO_W-1:0] r_wd_cnt;
    logic [TO_W-1:0] w_wd_cnt_nxt;
    logic            r_timeout_err;
    logic            w_timeout_err_nxt;
    logic [1:0]      r_grant;

    logic            w_req0;
    logic            w_req1;
    logic            w_tie_to_p1;

    assign w_req0 = bus.p0_read_en | bus.p0_write_en;
    assign w_req1 = bus.p1_read_en | bus.p1_write_en;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Port opposite the last completed owner wins a tie, so contention alternates.
    assign w_tie_to_p1 = ~r_last_grant;
`else
    assign w_tie_to_p1 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
            r_grant       <= 2'b00;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_grant       <= {w_state_nxt == BUSY1, w_state_nxt == BUSY0};
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        w_wd_cnt_nxt      = r_wd_cnt;
        w_timeout_err_nxt = r_timeout_err;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = w_tie_to_p1 ? BUSY1 : BUSY0;
                end else if (w_req0) begin
                    w_state_nxt = BUSY0;
                end else if (w_req1) begin
                    w_state_nxt = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (bus.SRAM_ready) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = (r_state == BUSY1);
                    w_wd_cnt_nxt     = '0;
                end else if (r_wd_cnt == LP_WD_LAST) begin
                    // Controller never answered: abandon the transfer without a ready pulse.
                    w_state_nxt       = IDLE;
                    w_wd_cnt_nxt      = '0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_wd_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.SRAM_read_en    = 1'b0;
        bus.SRAM_write_en   = 1'b0;
        bus.SRAM_addr       = '0;
        bus.SRAM_write_data = '0;
        bus.p0_ready        = 1'b0;
        bus.p0_read_data    = '0;
        bus.p1_ready        = 1'b0;
        bus.p1_read_data    = '0;
        case (r_state)
            BUSY0: begin
                // A simultaneous write wins over a read on the same port.
                bus.SRAM_write_en   = bus.p0_write_en;
                bus.SRAM_read_en    = bus.p0_read_en & ~bus.p0_write_en;
                bus.SRAM_addr       = bus.p0_addr;
                bus.SRAM_write_data = bus.p0_write_data;
                bus.p0_ready        = bus.SRAM_ready;
                if (bus.SRAM_ready && bus.p0_read_en && !bus.p0_write_en) begin
                    bus.p0_read_data = bus.SRAM_read_data;
                end
            end
            BUSY1: begin
                bus.SRAM_write_en   = bus.p1_write_en;
                bus.SRAM_read_en    = bus.p1_read_en & ~bus.p1_write_en;
                bus.SRAM_addr       = bus.p1_addr;
                bus.SRAM_write_data = bus.p1_write_data;
                bus.p1_ready        = bus.SRAM_ready;
                if (bus.SRAM_ready && bus.p1_read_en && !bus.p1_write_en) begin
                    bus.p1_read_data = bus.SRAM_read_data;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.grant       = r_grant;
    assign bus.timeout_err = r_timeout_err;

    assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized run against a cycle model.
module tb_sram_port_arbiter;

    localparam int TO = 4;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        bus.p0_read_en = 0; bus.p0_write_en = 0; bus.p0_addr = '0; bus.p0_write_data = '0;
        bus.p1_read_en = 0; bus.p1_write_en = 0; bus.p1_addr = '0; bus.p1_write_data = '0;
        bus.SRAM_ready = 0; bus.SRAM_read_data = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_idle();
        #1;
        n_cmp++;
        if (bus.grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got %b want 00", bus.grant); end
        n_cmp++;
        if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus.timeout_err); end
        n_cmp++;
        if ({bus.SRAM_read_en, bus.SRAM_write_en, bus.SRAM_addr, bus.SRAM_write_data} !== 66'd0) begin
            n_err++; $display("FAIL reset_sram got %b%b %h %h want all 0", bus.SRAM_read_en, bus.SRAM_write_en, bus.SRAM_addr, bus.SRAM_write_data);
        end
        n_cmp++;
        if ({bus.p0_ready, bus.p1_ready, bus.p0_read_data, bus.p1_read_data} !== 130'd0) begin
            n_err++; $display("FAIL reset_ports got rdy %b%b want 00, data nonzero", bus.p0_ready, bus.p1_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_p0_read;
        logic [63:0] d;
        d = 64'h11112222_33334444;
        test_reset();
        bus.p0_read_en = 1; bus.p0_addr = 32'h400;
        #1;
        n_cmp++;
        if (bus.SRAM_read_en !== 1'b0) begin n_err++; $display("FAIL p0rd_idle_en got %b want 0", bus.SRAM_read_en); end
        tick();
        for (int k = 1; k <= 3; k++) begin
            bus.SRAM_ready = (k == 3); bus.SRAM_read_data = d;
            #1;
            n_cmp++;
            if ({bus.grant, bus.SRAM_read_en, bus.SRAM_write_en, bus.SRAM_addr} !== {2'b01, 1'b1, 1'b0, 32'h400}) begin
                n_err++; $display("FAIL p0rd_busy%0d got g=%b rd=%b wr=%b a=%h want g=01 rd=1 wr=0 a=400", k, bus.grant, bus.SRAM_read_en, bus.SRAM_write_en, bus.SRAM_addr);
            end
            n_cmp++;
            if ({bus.p0_ready, bus.p0_read_data} !== {(k == 3), (k == 3) ? d : 64'd0}) begin
                n_err++; $display("FAIL p0rd_ready%0d got %b %h want %b", k, bus.p0_ready, bus.p0_read_data, (k == 3));
            end
            n_cmp++;
            if ({bus.p1_ready, bus.p1_read_data} !== 65'd0) begin
                n_err++; $display("FAIL p0rd_p1out%0d got %b %h want 0", k, bus.p1_ready, bus.p1_read_data);
            end
            tick();
        end
        drive_idle();
        #1;
        n_cmp++;
        if ({bus.grant, bus.SRAM_read_en} !== 3'b000) begin n_err++; $display("FAIL p0rd_done got g=%b rd=%b want 00 0", bus.grant, bus.SRAM_read_en); end
    endtask

    task automatic test_p1_write;
        test_reset();
        bus.p1_write_en = 1; bus.p1_addr = 32'h800; bus.p1_write_data = 32'hDEADBEEF;
        tick();
        bus.SRAM_ready = 1; bus.SRAM_read_data = 64'hA5A5A5A5_5A5A5A5A;
        #1;
        n_cmp++;
        if ({bus.grant, bus.SRAM_write_en, bus.SRAM_read_en, bus.SRAM_addr, bus.SRAM_write_data} !== {2'b10, 1'b1, 1'b0, 32'h800, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL p1wr_sram got g=%b wr=%b rd=%b a=%h d=%h want 10 1 0 800 deadbeef", bus.grant, bus.SRAM_write_en, bus.SRAM_read_en, bus.SRAM_addr, bus.SRAM_write_data);
        end
        n_cmp++;
        if ({bus.p1_ready, bus.p1_read_data} !== {1'b1, 64'd0}) begin
            n_err++; $display("FAIL p1wr_ready got %b %h want 1 0", bus.p1_ready, bus.p1_read_data);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_contention;
        int want;
        test_reset();
        bus.p0_read_en = 1; bus.p0_addr = 32'h100;
        bus.p1_write_en = 1; bus.p1_addr = 32'h200; bus.p1_write_data = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            want = RR ? (i % 2) : 0;
            tick();
            n_cmp++;
            if (bus.grant !== ((want == 0) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL contend_grant%0d got %b want port %0d", i, bus.grant, want);
            end
            bus.SRAM_ready = 1;
            #1;
            n_cmp++;
            if ({bus.p0_ready, bus.p1_ready} !== {(want == 0), (want == 1)}) begin
                n_err++; $display("FAIL contend_ready%0d got p0=%b p1=%b want port %0d", i, bus.p0_ready, bus.p1_ready, want);
            end
            tick();
            bus.SRAM_ready = 0;
        end
        drive_idle();
    endtask

    task automatic test_rw_both;
        test_reset();
        bus.p0_read_en = 1; bus.p0_write_en = 1; bus.p0_addr = 32'h40; bus.p0_write_data = 32'hCAFE0001;
        tick();
        bus.SRAM_ready = 1; bus.SRAM_read_data = {$urandom, $urandom} | 64'h1;
        #1;
        n_cmp++;
        if ({bus.SRAM_write_en, bus.SRAM_read_en} !== 2'b10) begin
            n_err++; $display("FAIL rw_both_en got wr=%b rd=%b want wr=1 rd=0", bus.SRAM_write_en, bus.SRAM_read_en);
        end
        n_cmp++;
        if ({bus.p0_ready, bus.p0_read_data} !== {1'b1, 64'd0}) begin
            n_err++; $display("FAIL rw_both_ready got %b %h want 1 0", bus.p0_ready, bus.p0_read_data);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_timeout;
        logic [63:0] d;
        d = 64'h0BAD_F00D_0000_7777;
        test_reset();
        bus.p1_read_en = 1; bus.p1_addr = 32'h44;
        tick();
        for (int k = 0; k < TO; k++) begin
            #1;
            n_cmp++;
            if ({bus.grant, bus.p1_ready, bus.timeout_err} !== {2'b10, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL to_wait%0d got g=%b rdy=%b err=%b want 10 0 0", k, bus.grant, bus.p1_ready, bus.timeout_err);
            end
            tick();
        end
        n_cmp++;
        if ({bus.grant, bus.timeout_err, bus.p1_ready} !== {2'b00, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL to_abort got g=%b err=%b rdy=%b want 00 1 0", bus.grant, bus.timeout_err, bus.p1_ready);
        end
        tick();
        bus.SRAM_ready = 1; bus.SRAM_read_data = d;
        #1;
        n_cmp++;
        if ({bus.grant, bus.p1_ready, bus.p1_read_data} !== {2'b10, 1'b1, d}) begin
            n_err++; $display("FAIL to_regrant got g=%b rdy=%b d=%h want 10 1 %h", bus.grant, bus.p1_ready, bus.p1_read_data, d);
        end
        tick();
        drive_idle();
        #1;
        n_cmp++;
        if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", bus.timeout_err); end
    endtask

    task automatic test_rst_mid;
        test_reset();
        bus.p1_write_en = 1; bus.p1_addr = 32'h800; bus.p1_write_data = 32'h55;
        tick();
        #1;
        n_cmp++;
        if ({bus.grant, bus.SRAM_write_en} !== 3'b101) begin n_err++; $display("FAIL rstmid_busy got g=%b wr=%b want 10 1", bus.grant, bus.SRAM_write_en); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.grant, bus.SRAM_write_en, bus.SRAM_read_en} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_drop got g=%b wr=%b rd=%b want 00 0 0", bus.grant, bus.SRAM_write_en, bus.SRAM_read_en);
        end
        bus.p0_read_en = 1; bus.p0_addr = 32'h10;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.grant !== 2'b01) begin n_err++; $display("FAIL rstmid_tie got %b want 01", bus.grant); end
        bus.SRAM_ready = 1;
        tick();
        drive_idle();
    endtask

    task automatic test_random;
        int owner, busy, last;
        bit err;
        bit rd[2], wr[2], req[2];
        logic [31:0] ad[2], wd[2];
        logic [63:0] sd;
        bit srdy;
        logic [67:0] exp_s;
        logic [129:0] exp_p;
        logic [63:0] exp_d;
        test_reset();
        owner = -1; busy = 0; last = 1; err = 0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                rd[p] = ($urandom_range(0, 2) == 0);
                wr[p] = ($urandom_range(0, 3) == 0);
                ad[p] = $urandom;
                wd[p] = $urandom;
                req[p] = rd[p] | wr[p];
            end
            srdy = ($urandom_range(0, 3) == 0);
            sd = {$urandom, $urandom};
            bus.p0_read_en = rd[0]; bus.p0_write_en = wr[0]; bus.p0_addr = ad[0]; bus.p0_write_data = wd[0];
            bus.p1_read_en = rd[1]; bus.p1_write_en = wr[1]; bus.p1_addr = ad[1]; bus.p1_write_data = wd[1];
            bus.SRAM_ready = srdy; bus.SRAM_read_data = sd;
            #1;
            exp_s = '0;
            exp_p = '0;
            if (owner >= 0) begin
                exp_s = {(owner == 1), (owner == 0), rd[owner] && !wr[owner], wr[owner], ad[owner], wd[owner]};
                exp_d = (srdy && rd[owner] && !wr[owner]) ? sd : 64'd0;
                exp_p = (owner == 0) ? {srdy, 1'b0, exp_d, 64'd0} : {1'b0, srdy, 64'd0, exp_d};
            end
            n_cmp++;
            if ({bus.grant, bus.SRAM_read_en, bus.SRAM_write_en, bus.SRAM_addr, bus.SRAM_write_data} !== exp_s) begin
                n_err++; $display("FAIL rand_sram c=%0d got %h want %h", c, {bus.grant, bus.SRAM_read_en, bus.SRAM_write_en, bus.SRAM_addr, bus.SRAM_write_data}, exp_s);
            end
            n_cmp++;
            if ({bus.p0_ready, bus.p1_ready, bus.p0_read_data, bus.p1_read_data} !== exp_p) begin
                n_err++; $display("FAIL rand_ports c=%0d got %h want %h", c, {bus.p0_ready, bus.p1_ready, bus.p0_read_data, bus.p1_read_data}, exp_p);
            end
            n_cmp++;
            if (bus.timeout_err !== err) begin n_err++; $display("FAIL rand_err c=%0d got %b want %b", c, bus.timeout_err, err); end
            if (owner < 0) begin
                if (req[0] && req[1]) owner = RR ? (1 - last) : 0;
                else if (req[0]) owner = 0;
                else if (req[1]) owner = 1;
            end else if (srdy) begin
                last = owner; owner = -1; busy = 0;
            end else begin
                busy++;
                if (busy == TO) begin err = 1; owner = -1; busy = 0; end
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_p0_read();
        test_p1_write();
        test_contention();
        test_rw_both();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
